seg7_scan_capture: RTL and testbench
====================================

// Module: seg7_scan_capture
// PURPOSE
//  Receive side of the 8-digit multiplexed seven-segment scan bus (COM active-low one-hot, ENS segment byte).
//  Samples the scanned COM/ENS lines, filters glitches and reassembles the eight per-digit segment patterns.
//  Publishes the eight patterns atomically once per complete frame.
//  Used for loopback checking of the display path and for reading external scanned displays.
// PARAMETERS
//  STABLE_CYC   1     consecutive identical samples (COM,ENS) needed to accept a digit; legal range 1..15
//  TIMEOUT_CYC  1024  cycles without an accepted digit before link is declared lost; minimum 16
// PORTS
//  iCLK         in   1   clock
//  nRST         in   1   reset, synchronous, active-low
//  iS_COM       in   8   scan common; bit k low selects digit k; all-high = blank
//  iS_ENS       in   8   segment byte: bit7=a,6=b,5=c,4=d,3=e,2=f,1=g,0=dp; 1 = segment lit
//  oSEG0..oSEG7 out  8   published pattern per digit, same bit order as iS_ENS
//  oFRAME_DONE  out  1   one-cycle pulse when oSEG0..7 are updated
//  oERR         out  1   one-cycle pulse on an illegal COM sample (more than one bit low)
//  oLINK        out  1   high after the first published frame; low after timeout
//  oHEX         out  32  [SEG7_HEX_DECODE_EN only] nibble k = hex value of oSEGk
//  oHEX_VLD     out  8   [SEG7_HEX_DECODE_EN only] bit k = oSEGk[7:1] matches a 0..F glyph
// BEHAVIOUR
//  Reset: all oSEGk=8'h00; oFRAME_DONE, oERR and oLINK = 0; shadow, seen-mask, counters and sample regs cleared.
//   Optional outputs: oHEX=0, oHEX_VLD=0.
//  Input stage: iS_COM and iS_ENS are registered once; no logic runs on raw inputs.
//  Stability: run counter increments while the registered (COM,ENS) pair equals the previous pair and reloads to 1 on change.
//   A sample is accepted exactly once per run, at the edge where the run length reaches STABLE_CYC.
//  Decode of an accepted sample:
//   COM one-hot-low (bit k) -> shadow[k] <= ENS and seen[k] <= 1; a digit repeated before the frame completes overwrites, no error.
//   COM all-high -> ignored; counts as activity for the timeout.
//   COM with more than one bit low -> oERR pulses, no shadow or seen update.
//   COM all-low is an illegal case of the above.
//  Latency at STABLE_CYC=1: input at edge t is registered at t+1 and accepted into the shadow at t+2.
//   Accept occurs at t+1+STABLE_CYC in general.
//  Frame: when seen becomes 8'hFF (last digit accepted at edge n), at edge n+1:
//   oSEG0..7 <= shadow (all at once), oFRAME_DONE = 1, oLINK <= 1, seen <= 0.
//   A digit accepted on edge n+1 lands in the cleared seen mask (new frame) and is not lost.
//  Timeout: idle counter reloads on every accepted sample, legal or blank.
//   On reaching TIMEOUT_CYC: oLINK <= 0 and seen <= 0; oSEGk keep their last published values.
//   Counter saturates (no wrap) until the next accept.
//  FSM (2 states): SYNC (oLINK=0) -> LOCKED on the first frame completion; LOCKED -> SYNC on timeout.
//   Reset enters SYNC. Frames complete and publish in both states.
//  Reset mid-frame: everything returns to reset values on the same edge; the partial shadow is discarded.
//  Counters are sized by $clog2 of the parameter and never overflow.
// CONFIGURATION
//  SEG7_HEX_DECODE_EN defined: oHEX/oHEX_VLD ports exist, combinational from published oSEGk.
//   Match ignores dp. Glyph table: 0=FC 1=60 2=DA 3=F2 4=66 5=B6 6=BE 7=E0 8=FE 9=F6 A=EE b=3E C=9C d=7A E=9E F=8E.
//   No match -> nibble 0 and VLD 0.
//  SEG7_HEX_DECODE_EN undefined: ports and decode logic are absent; all other behaviour is identical.
// STRUCTURE
//  seg7_pkg: segment bit-position constants (SEG_A..SEG_DP), glyph table, FSM state encoding (ST_SYNC, ST_LOCKED).
//   The glyph table is shared with the display encoder.
//  Sub-module seg7_glyph_dec: 8-bit pattern -> {vld, nibble}.
//   Instantiated 8x under SEG7_HEX_DECODE_EN.
// TESTING
//  1 Drive 8 digits in order COM=FE..7F with ENS=FC,60,DA,F2,66,B6,BE,E0, 1 cycle each, STABLE_CYC=1
//    -> oFRAME_DONE pulse 3 cycles after the last digit enters; oSEG0..7 = those values; oLINK=1.
//  2 Same frame with a 1-cycle glitch ENS=FF on digit 3, STABLE_CYC=2, 3 cycles per digit
//    -> oSEG3=F2 and oERR never pulses.
//  3 COM=F0 for 1 cycle mid-frame -> oERR pulse 2 cycles later; oSEG unchanged; frame still completes.
//  4 Digits sent in reverse order with digit 5 sent twice (ENS=00 then B6) -> single oFRAME_DONE; oSEG5=B6.
//  5 Complete a frame, then hold inputs static for TIMEOUT_CYC+2 cycles -> oLINK falls; oSEGk retained;
//    next full frame -> oLINK=1 again.
//  6 Assert nRST=0 after 4 of 8 digits, then release and send a full frame
//    -> all outputs 0 during reset; one oFRAME_DONE after release.
//    With SEG7_HEX_DECODE_EN: oHEX=32'h76543210, oHEX_VLD=FF for the scenario-1 data.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: segment bit positions, hex glyph table and capture FSM states shared by the seven-segment blocks.
package seg7_pkg;
   localparam int SEG_A  = 7;
   localparam int SEG_B  = 6;
   localparam int SEG_C  = 5;
   localparam int SEG_D  = 4;
   localparam int SEG_E  = 3;
   localparam int SEG_F  = 2;
   localparam int SEG_G  = 1;
   localparam int SEG_DP = 0;
   localparam logic [15:0][7:0] GLYPH = {
      8'h8E, 8'h9E, 8'h7A, 8'h9C, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
      8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
   };
   typedef enum logic {ST_SYNC = 1'b0, ST_LOCKED = 1'b1} state_t;
endpackage

// File: rtl/seg7_scan_capture_if.sv
// seg7_scan_capture_if: scan bus (COM active-low one-hot select, ENS segment byte) from driver to capture.
interface seg7_scan_capture_if;
   logic [7:0] iS_COM;
   logic [7:0] iS_ENS;
   modport master (output iS_COM, output iS_ENS);
   modport slave  (input  iS_COM, input  iS_ENS);
endinterface

// File: rtl/seg7_glyph_dec.sv
// seg7_glyph_dec: maps a segment pattern to its hex digit; dp is ignored, unknown shapes give vld=0, nibble 0.
module seg7_glyph_dec
   import seg7_pkg::*;
(
   input  logic [7:0] i_seg,
   output logic       o_vld,
   output logic [3:0] o_nib
);
   // Search the glyph table on the a..g segments only.
   always_comb begin
      o_vld = 1'b0;
      o_nib = 4'h0;
      for (int n = 0; n < 16; n++)
         if (i_seg[SEG_A:SEG_G] == GLYPH[n][SEG_A:SEG_G]) begin
            o_vld = 1'b1;
            o_nib = 4'(n);
         end
   end
endmodule

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: samples the scan bus, debounces it, rebuilds 8 digit patterns and publishes whole frames.
// Optional macro SEG7_HEX_DECODE_EN adds oHEX/oHEX_VLD decoded from the published patterns.
module seg7_scan_capture
   import seg7_pkg::*;
#(
   parameter int STABLE_CYC  = 1,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic               iCLK,
   input  logic               nRST,
   seg7_scan_capture_if.slave scan,
   output logic [7:0]         oSEG0,
   output logic [7:0]         oSEG1,
   output logic [7:0]         oSEG2,
   output logic [7:0]         oSEG3,
   output logic [7:0]         oSEG4,
   output logic [7:0]         oSEG5,
   output logic [7:0]         oSEG6,
   output logic [7:0]         oSEG7,
   output logic               oFRAME_DONE,
   output logic               oERR,
   output logic               oLINK
`ifdef SEG7_HEX_DECODE_EN
   ,
   output logic [31:0]        oHEX,
   output logic [7:0]         oHEX_VLD
`endif
);
   localparam int RW = $clog2(STABLE_CYC + 2);
   localparam int IW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [RW-1:0] RUN_ACC  = RW'(STABLE_CYC);
   localparam logic [RW-1:0] RUN_MAX  = RW'(STABLE_CYC + 1);
   localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYC);

   logic [7:0]      r_com, r_ens, r_pcom, r_pens, r_seen;
   logic            r_vld, r_pvld, r_done, r_err, r_link;
   logic [RW-1:0]   r_run;
   logic [IW-1:0]   r_idle;
   logic [7:0][7:0] r_shadow, r_seg;
   state_t          r_state;
   logic            w_same, w_acc, w_one, w_blank, w_bad, w_live, w_frame, w_to;
   logic [7:0]      w_sel, w_load;
   logic [RW-1:0]   w_run_nxt;

   // Classify the registered sample; the run counter saturates one past the accept point so each run accepts once.
   always_comb begin
      w_same    = r_pvld && r_com == r_pcom && r_ens == r_pens;
      w_run_nxt = !w_same ? RW'(1) : (r_run == RUN_MAX ? r_run : r_run + 1'b1);
      w_acc     = r_vld && w_run_nxt == RUN_ACC;
      w_sel     = ~r_com;
      w_one     = w_sel != 8'h00 && (w_sel & (w_sel - 8'h01)) == 8'h00;
      w_blank   = r_com == 8'hFF;
      w_bad     = !w_one && !w_blank;
      w_live    = w_acc && !w_bad;
      w_load    = (w_acc && w_one) ? w_sel : 8'h00;
      w_frame   = r_seen == 8'hFF;
      w_to      = !w_live && r_idle == IDLE_MAX - 1'b1;
   end

   // Input registers, debounce, shadow assembly, frame publish and idle timer.
   always_ff @(posedge iCLK) begin
      if (!nRST) begin
         r_com    <= 8'h00;
         r_ens    <= 8'h00;
         r_pcom   <= 8'h00;
         r_pens   <= 8'h00;
         r_vld    <= 1'b0;
         r_pvld   <= 1'b0;
         r_run    <= '0;
         r_idle   <= '0;
         r_seen   <= 8'h00;
         r_shadow <= '0;
         r_seg    <= '0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_com  <= scan.iS_COM;
         r_ens  <= scan.iS_ENS;
         r_vld  <= 1'b1;
         r_pcom <= r_com;
         r_pens <= r_ens;
         r_pvld <= r_vld;
         r_run  <= w_run_nxt;
         r_idle <= w_live ? '0 : (r_idle == IDLE_MAX ? r_idle : r_idle + 1'b1);
         r_err  <= w_acc && w_bad;
         r_done <= w_frame;
         if (w_frame)
            r_seg <= r_shadow;
         for (int k = 0; k < 8; k++)
            if (w_load[k])
               r_shadow[k] <= r_ens;
         r_seen <= ((w_frame || w_to) ? 8'h00 : r_seen) | w_load;
      end
   end

   // Link FSM: locks on the first published frame, drops back to sync on timeout.
   always_ff @(posedge iCLK) begin
      if (!nRST) begin
         r_state <= ST_SYNC;
         r_link  <= 1'b0;
      end else if (r_state == ST_SYNC && w_frame) begin
         r_state <= ST_LOCKED;
         r_link  <= 1'b1;
      end else if (r_state == ST_LOCKED && w_to) begin
         r_state <= ST_SYNC;
         r_link  <= 1'b0;
      end
   end

   assign oSEG0       = r_seg[0];
   assign oSEG1       = r_seg[1];
   assign oSEG2       = r_seg[2];
   assign oSEG3       = r_seg[3];
   assign oSEG4       = r_seg[4];
   assign oSEG5       = r_seg[5];
   assign oSEG6       = r_seg[6];
   assign oSEG7       = r_seg[7];
   assign oFRAME_DONE = r_done;
   assign oERR        = r_err;
   assign oLINK       = r_link;

`ifdef SEG7_HEX_DECODE_EN
   for (genvar k = 0; k < 8; k++) begin : g_hex
      seg7_glyph_dec u_dec (.i_seg(r_seg[k]), .o_vld(oHEX_VLD[k]), .o_nib(oHEX[4*k +: 4]));
   end
`endif
endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb_seg7_scan_capture: directed scenarios plus random traffic checked against a history-based reference model.
`timescale 1ns/1ps
module tb_seg7_scan_capture;
   localparam int S1 = 1;
   localparam int S2 = 2;
   localparam int T  = 64;

   typedef struct {
      logic [7:0] com;
      logic [7:0] ens;
      logic [7:0] exp_seg;
   } vec_t;

   logic iCLK = 1'b0;
   logic nRST = 1'b0;
   always #5 iCLK = ~iCLK;

   seg7_scan_capture_if bus();

   logic [7:0][7:0] s1, s2;
   logic            dn1, er1, lk1, dn2, er2, lk2;
`ifdef SEG7_HEX_DECODE_EN
   logic [31:0]     hx1, hx2;
   logic [7:0]      hv1, hv2;
`endif

   seg7_scan_capture #(.STABLE_CYC(S1), .TIMEOUT_CYC(T)) u1 (
      .iCLK(iCLK), .nRST(nRST), .scan(bus),
      .oSEG0(s1[0]), .oSEG1(s1[1]), .oSEG2(s1[2]), .oSEG3(s1[3]),
      .oSEG4(s1[4]), .oSEG5(s1[5]), .oSEG6(s1[6]), .oSEG7(s1[7]),
      .oFRAME_DONE(dn1), .oERR(er1), .oLINK(lk1)
`ifdef SEG7_HEX_DECODE_EN
      , .oHEX(hx1), .oHEX_VLD(hv1)
`endif
   );

   seg7_scan_capture #(.STABLE_CYC(S2), .TIMEOUT_CYC(T)) u2 (
      .iCLK(iCLK), .nRST(nRST), .scan(bus),
      .oSEG0(s2[0]), .oSEG1(s2[1]), .oSEG2(s2[2]), .oSEG3(s2[3]),
      .oSEG4(s2[4]), .oSEG5(s2[5]), .oSEG6(s2[6]), .oSEG7(s2[7]),
      .oFRAME_DONE(dn2), .oERR(er2), .oLINK(lk2)
`ifdef SEG7_HEX_DECODE_EN
      , .oHEX(hx2), .oHEX_VLD(hv2)
`endif
   );

   int n_chk = 0, n_fail = 0;
   int tc = 0, d1 = 0, d2 = 0, e1 = 0, e2 = 0, d1_cyc = 0, e1_cyc = 0;

   // Reference model: acceptance is found by measuring the run of identical samples in the sampled history.
   logic [15:0]     hist [$];
   int              mcyc = 0;
   logic [7:0][7:0] m_seg [2];
   logic [7:0][7:0] m_sh  [2];
   logic [7:0]      m_seen [2];
   logic            m_done [2], m_err [2], m_link [2];
   int              m_last [2];

   task automatic mstep(input int m);
      int s, run;
      logic [7:0] c, e, ld;
      bit live, err, fr, to;
      s = (m == 0) ? S1 : S2;
      run = 0; ld = 8'h00; live = 0; err = 0; c = 8'hFF; e = 8'h00;
      if (hist.size() > 0) begin
         run = 1;
         c = hist[hist.size()-1][15:8];
         e = hist[hist.size()-1][7:0];
         for (int i = hist.size() - 1; i > 0; i--) begin
            if (hist[i] != hist[i-1] || run > s) break;
            run++;
         end
      end
      if (run == s) begin
         if (c == 8'hFF) live = 1;
         else if ($countones(c) == 7) begin live = 1; ld = ~c; end
         else err = 1;
      end
      fr = (m_seen[m] == 8'hFF);
      to = !live && (mcyc - m_last[m] == T);
      m_done[m] = fr;
      m_err[m]  = err;
      if (fr) begin m_seg[m] = m_sh[m]; m_link[m] = 1'b1; end
      if (to) m_link[m] = 1'b0;
      for (int k = 0; k < 8; k++) if (ld[k]) m_sh[m][k] = e;
      m_seen[m] = ((fr || to) ? 8'h00 : m_seen[m]) | ld;
      if (live) m_last[m] = mcyc;
   endtask

   always @(posedge iCLK) begin
      mcyc++;
      if (!nRST) begin
         hist.delete();
         for (int m = 0; m < 2; m++) begin
            m_seg[m] = '0; m_sh[m] = '0; m_seen[m] = 8'h00;
            m_done[m] = 1'b0; m_err[m] = 1'b0; m_link[m] = 1'b0; m_last[m] = mcyc;
         end
      end else begin
         mstep(0);
         mstep(1);
         hist.push_back({bus.iS_COM, bus.iS_ENS});
         if (hist.size() > 20) void'(hist.pop_front());
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, tc);
      end
   endtask

   task automatic mcheck();
      chk("m1_seg",  s1,  m_seg[0]);
      chk("m1_done", dn1, m_done[0]);
      chk("m1_err",  er1, m_err[0]);
      chk("m1_link", lk1, m_link[0]);
      chk("m2_seg",  s2,  m_seg[1]);
      chk("m2_done", dn2, m_done[1]);
      chk("m2_err",  er2, m_err[1]);
      chk("m2_link", lk2, m_link[1]);
   endtask

   task automatic step();
      @(negedge iCLK);
      mcheck();
      if (dn1) begin d1++; d1_cyc = tc; end
      if (dn2) d2++;
      if (er1) begin e1++; e1_cyc = tc; end
      if (er2) e2++;
      @(posedge iCLK);
      #1;
      tc++;
   endtask

   task automatic send(input logic [7:0] c, input logic [7:0] e, input int n);
      bus.iS_COM = c;
      bus.iS_ENS = e;
      repeat (n) step();
   endtask

   task automatic wait_done(input int u, input int base, input int lim, input string nm);
      int n = 0;
      while (((u == 0) ? d1 : d2) == base && n < lim) begin step(); n++; end
      chk(nm, ((u == 0) ? d1 : d2) != base, 1);
   endtask

   initial begin
      vec_t            tbl [8];
      logic [7:0][7:0] fa, fb;
      int              ord [9];
      int              x, b, bd, r;
      logic [7:0]      c;
      fa = {8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC};
      fb = {8'h8E, 8'h9E, 8'h7A, 8'h9C, 8'h3E, 8'hEE, 8'hF6, 8'hFE};
      ord = '{7, 6, 5, 4, 3, 2, 1, 5, 0};
      for (int k = 0; k < 8; k++) tbl[k] = '{com: ~(8'h01 << k), ens: fa[k], exp_seg: fa[k]};
      x = 0;
      bus.iS_COM = 8'hFF;
      bus.iS_ENS = 8'h00;
      repeat (3) step();
      chk("rst_seg", s1, 64'h0);
      chk("rst_flags", {dn1, er1, lk1}, 3'b000);
      nRST = 1'b1;
      // 1: one frame, one cycle per digit
      b = d1;
      for (int k = 0; k < 8; k++) begin x = tc; send(tbl[k].com, tbl[k].ens, 1); end
      bus.iS_COM = 8'hFF;
      repeat (3) step();
      chk("t1_done_cnt", d1 - b, 1);
      chk("t1_done_lat", d1_cyc - x, 3);
      for (int k = 0; k < 8; k++) chk("t1_seg", s1[k], tbl[k].exp_seg);
      chk("t1_link", lk1, 1'b1);
`ifdef SEG7_HEX_DECODE_EN
      chk("t1_hex", hx1, 32'h76543210);
      chk("t1_hex_vld", hv1, 8'hFF);
`endif
      // 2: glitch on digit 3 with STABLE_CYC=2
      b = e2; bd = d2;
      for (int k = 0; k < 8; k++)
         if (k == 3) begin send(tbl[k].com, 8'hFF, 1); send(tbl[k].com, tbl[k].ens, 2); end
         else send(tbl[k].com, tbl[k].ens, 3);
      bus.iS_COM = 8'hFF;
      wait_done(1, bd, 8, "t2_done");
      chk("t2_seg3", s2[3], 8'hF2);
      chk("t2_seg", s2, fa);
      chk("t2_no_err", e2 - b, 0);
      // 3: illegal COM mid-frame
      b = e1; bd = d1;
      for (int k = 0; k < 4; k++) send(tbl[k].com, fb[k], 1);
      x = tc;
      send(8'hF0, 8'h55, 1);
      send(tbl[4].com, fb[4], 2);
      chk("t3_seg_hold", s1, fa);
      for (int k = 5; k < 8; k++) send(tbl[k].com, fb[k], 1);
      bus.iS_COM = 8'hFF;
      wait_done(0, bd, 8, "t3_done");
      chk("t3_err_cnt", e1 - b, 1);
      chk("t3_err_lat", e1_cyc - x, 2);
      chk("t3_seg", s1, fb);
`ifdef SEG7_HEX_DECODE_EN
      chk("t3_hex", hx1, 32'hFEDCBA98);
`endif
      // 4: reverse order, digit 5 repeated
      bd = d1;
      for (int i = 0; i < 9; i++) send(tbl[ord[i]].com, (i == 2) ? 8'h00 : tbl[ord[i]].ens, 2);
      bus.iS_COM = 8'hFF;
      repeat (6) step();
      chk("t4_done_cnt", d1 - bd, 1);
      chk("t4_seg5", s1[5], 8'hB6);
      chk("t4_seg", s1, fa);
      // 5: timeout and recovery
      chk("t5_link_pre", lk1, 1'b1);
      repeat (T + 2) step();
      chk("t5_link_lost", lk1, 1'b0);
      chk("t5_seg_kept", s1, fa);
      bd = d1;
      for (int k = 0; k < 8; k++) send(tbl[k].com, fb[k], 1);
      bus.iS_COM = 8'hFF;
      wait_done(0, bd, 8, "t5_done");
      chk("t5_link_back", lk1, 1'b1);
      chk("t5_seg", s1, fb);
      // 6: reset mid-frame discards the partial frame
      for (int k = 0; k < 4; k++) send(tbl[k].com, fb[k], 1);
      nRST = 1'b0;
      repeat (2) step();
      chk("t6_rst_seg", s1, 64'h0);
      chk("t6_rst_flags", {dn1, er1, lk1}, 3'b000);
      nRST = 1'b1;
      bd = d1;
      for (int k = 4; k < 8; k++) send(tbl[k].com, fa[k], 2);
      for (int k = 0; k < 4; k++) send(tbl[k].com, fa[k], 2);
      bus.iS_COM = 8'hFF;
      repeat (6) step();
      chk("t6_done_cnt", d1 - bd, 1);
      chk("t6_seg", s1, fa);
      // random traffic against the model
      for (int i = 0; i < 500; i++) begin
         r = $urandom_range(0, 9);
         c = (r < 7) ? ~(8'h01 << $urandom_range(0, 7)) : (r == 7) ? 8'hFF : 8'($urandom);
         send(c, 8'($urandom), $urandom_range(1, 3));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
